jtpopeye_objdma: RTL and testbench
==================================

Name: jtpopeye_objdma

Overview:
- Object-attribute DMA engine, downstream of the video timing generator.
- On each vertical-blank start it halts the CPU through the Z80 bus-request handshake. It then copies a fixed block of object attributes from CPU work RAM into the object buffer RAM read by the sprite renderer.
- All activity advances on pxl2_cen only.

Parameters:
- AW, 10, width of CPU RAM source address.
- SRC_BASE, 10'h000, first source byte address.
- LEN, 384, bytes per transfer (96 objects × 4 bytes); legal range 1..512.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- pxl2_cen  in  1  clock enable, 2× pixel rate
- VB  in  1  vertical blank from timing generator, active high
- busrq_n  out  1  Z80 bus request, active low
- busak_n  in  1  Z80 bus acknowledge, active low
- src_addr  out  AW  CPU RAM read address
- src_cs  out  1  CPU RAM select, DMA side
- src_dout  in  8  CPU RAM read data; synchronous, valid one pxl2_cen after address
- obj_addr  out  9  object RAM write address
- obj_din  out  8  object RAM write data
- obj_we  out  1  object RAM write strobe
- dma_busy  out  1  high from request until bus released
- dma_err  out  1  sticky: last transfer truncated

Behaviour:
- Reset (async, rst_n=0): state IDLE; busrq_n=1; src_cs=0; obj_we=0; src_addr=SRC_BASE; obj_addr=0; obj_din=0; dma_busy=0; dma_err=0; VB edge register=0.
- VB rise detection: VB is registered on pxl2_cen. A start event is VB=1 while the registered VB=0. No start is detected on the first cen after reset unless VB was 0 before it.
- Every state transition and every output change occurs only on cycles with pxl2_cen=1.
- States:
  - IDLE: on start event -> REQ. busrq_n<=0, dma_busy<=1, dma_err<=0, byte counter<=0.
  - REQ: wait for busak_n=0 (sampled on cen). Then -> RD, with src_cs<=1 and src_addr<=SRC_BASE.
  - REQ abort: if VB=0 while in REQ -> REL, dma_err<=1, no bytes written.
  - RD: address is on src_addr. Next cen -> WR. obj_din<=src_dout (data valid now), obj_addr<=counter, obj_we<=1.
  - WR: obj_we<=0.
    - If counter==LEN-1 -> REL.
    - Else if VB=0 -> REL with dma_err<=1 (truncated after the completed byte).
    - Else counter+1, src_addr+1 -> RD.
  - REL: src_cs<=0, busrq_n<=1. Wait for busak_n=1. Then dma_busy<=0 -> IDLE.
- Throughput: 2 pxl2_cen per byte. Full transfer = LEN×2 cen plus handshake.
- obj_we: high for exactly one pxl2_cen period per byte. obj_addr and obj_din are stable during that whole period.
- Width rules: counter is 9 bits. src_addr = SRC_BASE + counter, modulo 2^AW (wraps silently at the top of the address space).
- A start event while not IDLE is ignored; there is no queued retrigger.
- busak_n released by the CPU mid-transfer (protocol violation): the transfer continues; no check is made.
- Reset mid-transfer: immediate return to reset values; busrq_n goes high asynchronously.
- dma_err is cleared only at the next start event or by reset.

Test Plan:
- Normal frame: LEN=384, SRC_BASE=0, RAM[i]=i^8'h5A, busak_n asserted 3 cen after busrq_n, VB held high. Expect 384 obj_we pulses, obj RAM[i]==i^8'h5A, busrq_n back high, dma_busy=0, dma_err=0, about 768+handshake cen.
- Late ack: hold busak_n=1 for 50 cen after request. Expect src_cs=0, no obj_we, busrq_n held low; transfer then proceeds normally.
- VB falls mid-transfer after byte 100 is written. Expect exactly 101 writes (0..100), then REL, busrq_n=1, dma_err=1. The next VB rise clears dma_err and performs a full 384-byte copy.
- Retrigger: pulse VB low/high during a transfer with VB back high within one cen. Expect the first event truncates per the rule above and the second start is ignored while busy.
- Async reset asserted mid-RD with no pxl2_cen pending. Expect busrq_n=1, obj_we=0, dma_busy=0 immediately. After release, no transfer occurs until a new VB rise.
- Address wrap: AW=10, SRC_BASE=10'h3FE, LEN=4. Expect reads at 3FE, 3FF, 000, 001 and obj_addr 0..3.

Source files
------------

// File: rtl/jtpopeye_objdma_if.sv
// Bus bundle between the object DMA engine, the Z80 bus arbiter, CPU work RAM
// and the object buffer RAM.
interface jtpopeye_objdma_if #(
    parameter int AW = 10
);
    logic          busrq_n;
    logic          busak_n;
    logic [AW-1:0] src_addr;
    logic          src_cs;
    logic [7:0]    src_dout;
    logic [8:0]    obj_addr;
    logic [7:0]    obj_din;
    logic          obj_we;

    modport master (
        output busrq_n, src_addr, src_cs, obj_addr, obj_din, obj_we,
        input  busak_n, src_dout
    );

    modport slave (
        input  busrq_n, src_addr, src_cs, obj_addr, obj_din, obj_we,
        output busak_n, src_dout
    );
endinterface

// File: rtl/jtpopeye_objdma.sv
// Object-attribute DMA: on each VB rise, grabs the Z80 bus and copies LEN bytes
// from CPU work RAM into the object buffer RAM, two pxl2_cen per byte.
module jtpopeye_objdma #(
    parameter int            AW       = 10,
    parameter logic [AW-1:0] SRC_BASE = '0,
    parameter int            LEN      = 384
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  pxl2_cen,
    input  logic                  VB,
    jtpopeye_objdma_if.master     bus,
    output logic                  dma_busy,
    output logic                  dma_err
);

    typedef enum logic [2:0] {IDLE, REQ, RD, WR, REL} state_t;

    localparam logic [8:0] LAST = 9'(LEN - 1);

    state_t        state_q;
    logic          vb_q;
    logic          armed_q;
    logic [8:0]    cnt_q;
    logic          busrq_n_q;
    logic          src_cs_q;
    logic [AW-1:0] src_addr_q;
    logic [8:0]    obj_addr_q;
    logic [7:0]    obj_din_q;
    logic          obj_we_q;
    logic          busy_q;
    logic          err_q;
    logic          start;

    // armed_q suppresses a false edge on the first cen after reset, when vb_q
    // has not yet seen the real VB level.
    assign start = armed_q & VB & ~vb_q;

    // NOTE: all state uses non-blocking assignments so every register samples
    // pre-edge values; blocking here would let later lines see updated state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            vb_q       <= 1'b0;
            armed_q    <= 1'b0;
            cnt_q      <= '0;
            busrq_n_q  <= 1'b1;
            src_cs_q   <= 1'b0;
            src_addr_q <= SRC_BASE;
            obj_addr_q <= '0;
            obj_din_q  <= '0;
            obj_we_q   <= 1'b0;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
        end else if (pxl2_cen) begin
            vb_q    <= VB;
            armed_q <= 1'b1;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q   <= REQ;
                        busrq_n_q <= 1'b0;
                        busy_q    <= 1'b1;
                        err_q     <= 1'b0;
                        cnt_q     <= '0;
                    end
                end
                REQ: begin
                    // Blanking ended before the CPU let go: give up this frame.
                    if (!VB) begin
                        state_q <= REL;
                        err_q   <= 1'b1;
                    end else if (!bus.busak_n) begin
                        state_q    <= RD;
                        src_cs_q   <= 1'b1;
                        src_addr_q <= SRC_BASE;
                    end
                end
                RD: begin
                    state_q    <= WR;
                    obj_din_q  <= bus.src_dout;
                    obj_addr_q <= cnt_q;
                    obj_we_q   <= 1'b1;
                end
                WR: begin
                    obj_we_q <= 1'b0;
                    if (cnt_q == LAST) begin
                        state_q <= REL;
                    end else if (!VB) begin
                        state_q <= REL;
                        err_q   <= 1'b1;
                    end else begin
                        state_q    <= RD;
                        cnt_q      <= cnt_q + 9'd1;
                        src_addr_q <= src_addr_q + 1'b1;
                    end
                end
                REL: begin
                    src_cs_q  <= 1'b0;
                    busrq_n_q <= 1'b1;
                    if (bus.busak_n) begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.busrq_n  = busrq_n_q;
    assign bus.src_cs   = src_cs_q;
    assign bus.src_addr = src_addr_q;
    assign bus.obj_addr = obj_addr_q;
    assign bus.obj_din  = obj_din_q;
    assign bus.obj_we   = obj_we_q;
    assign dma_busy     = busy_q;
    assign dma_err      = err_q;

endmodule

// File: tb/tb_jtpopeye_objdma.sv
// Directed bench for jtpopeye_objdma: a 384-byte instance for frame behaviour
// and a 4-byte instance near the top of the address space for wrap-around.
module tb_jtpopeye_objdma;

    logic clk   = 1'b0;
    logic cen   = 1'b0;
    logic rst_n = 1'b0;
    logic vb1   = 1'b0;
    logic vb2   = 1'b0;
    logic busy1, err1, busy2, err2;

    int vectors     = 0;
    int miscompares = 0;
    int ack_dly     = 3;
    int wr1         = 0;
    int wr2         = 0;

    logic [7:0] ram1 [1024];
    logic [7:0] ram2 [1024];
    logic [7:0] obj1 [512];

    jtpopeye_objdma_if #(.AW(10)) if1 ();
    jtpopeye_objdma_if #(.AW(10)) if2 ();

    jtpopeye_objdma #(.AW(10), .SRC_BASE(10'h000), .LEN(384)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .pxl2_cen(cen), .VB(vb1),
        .bus(if1), .dma_busy(busy1), .dma_err(err1)
    );

    jtpopeye_objdma #(.AW(10), .SRC_BASE(10'h3FE), .LEN(4)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .pxl2_cen(cen), .VB(vb2),
        .bus(if2), .dma_busy(busy2), .dma_err(err2)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cen <= ~cen;

    // Synchronous CPU RAMs; data settles well before the following cen edge.
    always @(posedge clk) begin
        if1.src_dout <= ram1[if1.src_addr];
        if2.src_dout <= ram2[if2.src_addr];
    end

    // Object RAM capture: one write per cen edge that sees obj_we high.
    always @(posedge clk) begin
        if (cen && if1.obj_we === 1'b1) begin
            obj1[if1.obj_addr] = if1.obj_din;
            wr1 = wr1 + 1;
        end
        if (cen && if2.obj_we === 1'b1) wr2 = wr2 + 1;
    end

    // Z80 arbiter: grants the bus ack_dly cens after busrq_n is seen low.
    initial begin
        int rc;
        rc = 0;
        if1.busak_n = 1'b1;
        if2.busak_n = 1'b1;
        forever begin
            do @(posedge clk); while (!cen);
            if (if1.busrq_n === 1'b0 || if2.busrq_n === 1'b0) rc = rc + 1;
            else rc = 0;
            #1;
            if (rc >= ack_dly) begin
                if1.busak_n = 1'b0;
                if2.busak_n = 1'b0;
            end else if (rc == 0) begin
                if1.busak_n = 1'b1;
                if2.busak_n = 1'b1;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors = vectors + 1;
        assert (obs === exp) else begin
            miscompares = miscompares + 1;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            do @(posedge clk); while (!cen);
            #1;
        end
    endtask

    task automatic wait_done(input bit which, input int max, output int n);
        n = 0;
        while (n < max && (which ? busy2 : busy1)) begin
            step(1);
            n = n + 1;
        end
        check(which ? "done2_timeout" : "done1_timeout", which ? busy2 : busy1, 0);
    endtask

    task automatic wait_byte1(input logic [8:0] addr, input string tag);
        int k;
        k = 0;
        while (k < 2000 && !(if1.obj_we === 1'b1 && if1.obj_addr == addr)) begin
            step(1);
            k = k + 1;
        end
        check(tag, if1.obj_we, 1);
    endtask

    initial begin
        int n, base, bad, k;
        logic [9:0] rd_addr [$];
        logic [8:0] wr_addr [$];
        logic [7:0] wr_data [$];
        logic [9:0] ea;

        for (int i = 0; i < 1024; i++) begin
            ram1[i] = 8'(i) ^ 8'h5A;
            ram2[i] = 8'(i) ^ 8'hC3;
        end

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        check("rst_busrq_n", if1.busrq_n, 1);
        check("rst_src_cs", if1.src_cs, 0);
        check("rst_obj_we", if1.obj_we, 0);
        check("rst_src_addr", if1.src_addr, 10'h000);
        check("rst_obj_addr", if1.obj_addr, 0);
        check("rst_obj_din", if1.obj_din, 0);
        check("rst_busy", busy1, 0);
        check("rst_err", err1, 0);
        check("rst_src_addr2", if2.src_addr, 10'h3FE);
        rst_n = 1'b1;
        step(4);
        check("idle_busrq_n", if1.busrq_n, 1);

        // Normal frame
        base = wr1;
        vb1 = 1'b1;
        step(1);
        check("t1_busrq_low", if1.busrq_n, 0);
        check("t1_busy", busy1, 1);
        check("t1_cs_before_ack", if1.src_cs, 0);
        step(10);
        check("t1_cs_active", if1.src_cs, 1);
        wait_done(1'b0, 2000, n);
        n = n + 11;
        check("t1_writes", wr1 - base, 384);
        bad = 0;
        for (int i = 0; i < 384; i++) if (obj1[i] !== (8'(i) ^ 8'h5A)) bad = bad + 1;
        check("t1_data_errors", bad, 0);
        check("t1_busrq_high", if1.busrq_n, 1);
        check("t1_err", err1, 0);
        check("t1_cen_count_in_range", (n >= 768 && n <= 800), 1);

        // Late acknowledge
        vb1 = 1'b0;
        step(4);
        ack_dly = 50;
        base = wr1;
        vb1 = 1'b1;
        step(40);
        check("t2_busrq_held", if1.busrq_n, 0);
        check("t2_cs_idle", if1.src_cs, 0);
        check("t2_no_writes", wr1 - base, 0);
        check("t2_busy", busy1, 1);
        wait_done(1'b0, 2000, n);
        check("t2_writes", wr1 - base, 384);
        check("t2_err", err1, 0);
        ack_dly = 3;

        // VB falls while byte 100 is being written
        vb1 = 1'b0;
        step(4);
        base = wr1;
        vb1 = 1'b1;
        wait_byte1(9'd100, "t3_reach_byte100");
        vb1 = 1'b0;
        wait_done(1'b0, 100, n);
        check("t3_writes", wr1 - base, 101);
        check("t3_err", err1, 1);
        check("t3_busrq_high", if1.busrq_n, 1);
        base = wr1;
        vb1 = 1'b1;
        step(1);
        check("t3_err_cleared", err1, 0);
        check("t3_restart_busy", busy1, 1);
        wait_done(1'b0, 2000, n);
        check("t3_full_writes", wr1 - base, 384);
        check("t3_full_err", err1, 0);

        // Retrigger: VB glitch low/high mid-transfer
        vb1 = 1'b0;
        step(4);
        base = wr1;
        vb1 = 1'b1;
        wait_byte1(9'd20, "t4_reach_byte20");
        vb1 = 1'b0;
        step(1);
        vb1 = 1'b1;
        wait_done(1'b0, 100, n);
        check("t4_writes", wr1 - base, 21);
        check("t4_err", err1, 1);
        step(10);
        check("t4_no_retrigger_busy", busy1, 0);
        check("t4_no_retrigger_busrq", if1.busrq_n, 1);
        check("t4_no_extra_writes", wr1 - base, 21);

        // Asynchronous reset in RD, between cen edges
        vb1 = 1'b0;
        step(4);
        base = wr1;
        vb1 = 1'b1;
        k = 0;
        while (k < 200 && !(if1.src_cs === 1'b1 && if1.obj_we === 1'b0 && (wr1 - base) >= 5)) begin
            step(1);
            k = k + 1;
        end
        check("t5_reach_rd", if1.src_cs, 1);
        rst_n = 1'b0;
        #1;
        check("t5_busrq_async", if1.busrq_n, 1);
        check("t5_obj_we_async", if1.obj_we, 0);
        check("t5_busy_async", busy1, 0);
        check("t5_cs_async", if1.src_cs, 0);
        #2;
        rst_n = 1'b1;
        step(20);
        check("t5_stay_idle_busrq", if1.busrq_n, 1);
        check("t5_stay_idle_busy", busy1, 0);
        vb1 = 1'b0;
        step(2);
        base = wr1;
        vb1 = 1'b1;
        step(1);
        check("t5_new_rise_busy", busy1, 1);
        wait_done(1'b0, 2000, n);
        check("t5_writes", wr1 - base, 384);

        // Source address wrap at the top of the 10-bit space
        base = wr2;
        vb2 = 1'b1;
        k = 0;
        while (k < 50 && if2.src_cs !== 1'b1) begin
            step(1);
            k = k + 1;
        end
        check("t6_first_addr", if2.src_addr, 10'h3FE);
        k = 0;
        while (k < 100 && busy2) begin
            if (if2.obj_we === 1'b1) begin
                rd_addr.push_back(if2.src_addr);
                wr_addr.push_back(if2.obj_addr);
                wr_data.push_back(if2.obj_din);
            end
            step(1);
            k = k + 1;
        end
        check("t6_done", busy2, 0);
        check("t6_writes", wr2 - base, 4);
        check("t6_logged", rd_addr.size(), 4);
        for (int i = 0; i < 4 && i < rd_addr.size(); i++) begin
            ea = 10'h3FE + 10'(i);
            check($sformatf("t6_src_addr%0d", i), rd_addr[i], ea);
            check($sformatf("t6_obj_addr%0d", i), wr_addr[i], i);
            check($sformatf("t6_obj_din%0d", i), wr_data[i], ram2[ea]);
        end
        check("t6_err", err2, 0);
        check("t6_busrq_high", if2.busrq_n, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
